acf_axis_reader: RTL and testbench

- Consumer end of the correlator's ACF output interface.
- Captures an 8-bin ACF snapshot whenever the correlator pulses its update strobe, then streams it as an AXI4-Stream frame: one header beat followed by one beat per bin.
- Holds one pending snapshot while the current frame drains. Sits between singleCFBlock instances and the AXI DMA/FIFO path.

---
 rtl/acf_axis_reader.sv | 162 ++++++++++++++++
 tb/tb_acf_axis_reader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acf_axis_reader.sv
// acf_axis_reader: latches ACF snapshots from the correlator and streams each one
// as an AXI4-Stream frame (one header beat, then one beat per bin).
module acf_axis_reader #(
  parameter int          NBINS       = 8,
  parameter int          ACF_WIDTH   = 16,
  parameter int          TDATA_WIDTH = 32,
  parameter logic [15:0] MAGIC       = 16'hAC0F
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         en,
  input  logic [NBINS*ACF_WIDTH-1:0]   acf_in,
  input  logic                         update_in,
  output logic [TDATA_WIDTH-1:0]       m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         busy,
  output logic [15:0]                  seq,
  output logic [15:0]                  drop_cnt
);

  localparam int SNAP_W = NBINS * ACF_WIDTH;
  localparam int IDX_W  = (NBINS > 1) ? $clog2(NBINS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBINS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA
  } state_t;

  state_t                 state_q, state_d;
  logic [SNAP_W-1:0]      pending_q, pending_d;
  logic [SNAP_W-1:0]      active_q, active_d;
  logic                   pending_valid_q, pending_valid_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [15:0]            seq_q, seq_d;
  logic [15:0]            drop_cnt_q, drop_cnt_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;

  logic                   accept;
  logic                   last_accept;
  logic                   pending_release;
  logic                   capture;
  logic [ACF_WIDTH-1:0]   bin_sel;

  // Frame sequencing plus the pending slot; a slot being emptied this cycle may refill.
  always_comb begin
    state_d         = state_q;
    pending_d       = pending_q;
    active_d        = active_q;
    pending_valid_d = pending_valid_q;
    idx_d           = idx_q;
    seq_d           = seq_q;
    drop_cnt_d      = drop_cnt_q;

    accept          = tvalid_q & m_axis_tready;
    last_accept     = accept && (state_q == S_DATA) && (idx_q == LAST_IDX);
    pending_release = pending_valid_q && ((state_q == S_IDLE) || last_accept);
    capture         = en & update_in;

    unique case (state_q)
      S_IDLE: begin
        if (pending_valid_q) begin
          active_d = pending_q;
          state_d  = S_HDR;
        end
      end
      S_HDR: begin
        if (accept) begin
          seq_d   = seq_q + 16'd1;
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + IDX_W'(1);
          end else if (pending_valid_q) begin
            active_d = pending_q;
            state_d  = S_HDR;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pending_release) begin
      pending_valid_d = 1'b0;
    end

    if (capture) begin
      if (!pending_valid_q || pending_release) begin
        pending_d       = acf_in;
        pending_valid_d = 1'b1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  // Bin 0 sits in the most-significant slice of the snapshot.
  always_comb begin
    bin_sel = '0;
    for (int i = 0; i < NBINS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        bin_sel = active_d[(NBINS-1-i)*ACF_WIDTH +: ACF_WIDTH];
      end
    end
  end

  always_comb begin
    tvalid_d = (state_d != S_IDLE);
    tlast_d  = (state_d == S_DATA) && (idx_d == LAST_IDX);
    tdata_d  = '0;
    if (state_d == S_HDR) begin
      tdata_d[31:0] = {MAGIC, seq_d};
    end else if (state_d == S_DATA) begin
      tdata_d[ACF_WIDTH-1:0] = bin_sel;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q         <= S_IDLE;
      pending_q       <= '0;
      active_q        <= '0;
      pending_valid_q <= 1'b0;
      idx_q           <= '0;
      seq_q           <= 16'd0;
      drop_cnt_q      <= 16'd0;
      tvalid_q        <= 1'b0;
      tlast_q         <= 1'b0;
      tdata_q         <= '0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      active_q        <= active_d;
      pending_valid_q <= pending_valid_d;
      idx_q           <= idx_d;
      seq_q           <= seq_d;
      drop_cnt_q      <= drop_cnt_d;
      tvalid_q        <= tvalid_d;
      tlast_q         <= tlast_d;
      tdata_q         <= tdata_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = (state_q != S_IDLE) | pending_valid_q;
  assign seq           = seq_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_acf_axis_reader.sv
// tb_acf_axis_reader: directed scenarios for acf_axis_reader with hand-computed
// expected beats, checked one cycle after each active clock edge.
module tb_acf_axis_reader;

  logic         CLK;
  logic         RST;
  logic         en;
  logic [127:0] acf_in;
  logic         update_in;
  logic [31:0]  tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic         busy;
  logic [15:0]  seq;
  logic [15:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  acf_axis_reader #(
    .NBINS(8), .ACF_WIDTH(16), .TDATA_WIDTH(32), .MAGIC(16'hAC0F)
  ) dut (
    .CLK(CLK), .RST(RST), .en(en), .acf_in(acf_in), .update_in(update_in),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .busy(busy), .seq(seq), .drop_cnt(drop_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Snapshot whose bin i holds base+i, bin 0 in the top slice.
  function automatic logic [127:0] make_snap(input logic [15:0] base);
    logic [127:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s[(7-i)*16 +: 16] = base + 16'(i);
    return s;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; en = 1'b1; update_in = 1'b0; tready = 1'b0; acf_in = '0;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; en = 1'b1; update_in = 1'b0; tready = 1'b0; acf_in = '0;
    tick(); tick();
    RST = 1'b0;
    checks++; if (tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid: got %b expected 0", tvalid); end
    checks++; if (tlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_tlast: got %b expected 0", tlast); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (tdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_tdata: got %h expected 00000000", tdata); end
    checks++; if (seq !== 16'h0) begin errors++; $display("[TB] FAIL reset_seq: got %h expected 0000", seq); end
    checks++; if (drop_cnt !== 16'h0) begin errors++; $display("[TB] FAIL reset_drop: got %h expected 0000", drop_cnt); end
  endtask

  task automatic test_single();
    tready = 1'b1;
    acf_in = make_snap(16'h0001); update_in = 1'b1;
    tick();
    update_in = 1'b0;
    checks++; if (tvalid !== 1'b0) begin errors++; $display("[TB] FAIL single_latency_early: tvalid got %b expected 0", tvalid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_pending: got %b expected 1", busy); end
    tick();
    checks++; if (tvalid !== 1'b1 || tdata !== 32'hAC0F0000 || tlast !== 1'b0) begin
      errors++; $display("[TB] FAIL single_header: got v=%b d=%h l=%b expected v=1 d=ac0f0000 l=0", tvalid, tdata, tlast);
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++; if (tvalid !== 1'b1 || tdata !== 32'(i + 1) || tlast !== (i == 7)) begin
        errors++; $display("[TB] FAIL single_beat%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b", i, tvalid, tdata, tlast, 32'(i + 1), (i == 7));
      end
      tick();
    end
    checks++; if (tvalid !== 1'b0) begin errors++; $display("[TB] FAIL single_end_tvalid: got %b expected 0", tvalid); end
    checks++; if (seq !== 16'd1) begin errors++; $display("[TB] FAIL single_seq: got %h expected 0001", seq); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_end_busy: got %b expected 0", busy); end
  endtask

  task automatic test_stall();
    int          accepts;
    logic        was_stalled;
    logic [31:0] held_data;
    logic        held_last;
    logic [31:0] exp;
    accepts = 0; was_stalled = 1'b0; held_data = '0; held_last = 1'b0;
    tready = 1'b0;
    acf_in = make_snap(16'h0001); update_in = 1'b1;
    tick();
    update_in = 1'b0;
    for (int c = 0; c < 60 && accepts < 9; c++) begin
      tready = ((c % 4) == 0) || ((c % 4) == 3);
      if (was_stalled) begin
        checks++; if (tvalid !== 1'b1 || tdata !== held_data || tlast !== held_last) begin
          errors++; $display("[TB] FAIL stall_hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b", tvalid, tdata, tlast, held_data, held_last);
        end
      end
      if (tvalid === 1'b1) begin
        if (tready) begin
          exp = (accepts == 0) ? 32'hAC0F0001 : 32'(accepts);
          checks++; if (tdata !== exp || tlast !== (accepts == 8)) begin
            errors++; $display("[TB] FAIL stall_beat%0d: got d=%h l=%b expected d=%h l=%b", accepts, tdata, tlast, exp, (accepts == 8));
          end
          accepts++;
        end
        was_stalled = !tready;
        held_data = tdata; held_last = tlast;
      end else begin
        was_stalled = 1'b0;
      end
      tick();
    end
    tready = 1'b0;
    checks++; if (accepts != 9) begin errors++; $display("[TB] FAIL stall_accepts: got %0d expected 9", accepts); end
    checks++; if (tvalid !== 1'b0) begin errors++; $display("[TB] FAIL stall_end_tvalid: got %b expected 0", tvalid); end
    checks++; if (seq !== 16'd2) begin errors++; $display("[TB] FAIL stall_seq: got %h expected 0002", seq); end
  endtask

  task automatic test_drop();
    logic [31:0] exp;
    logic [15:0] base;
    do_reset();
    tready = 1'b0; update_in = 1'b1;
    acf_in = make_snap(16'h0010); tick();
    acf_in = make_snap(16'h0020); tick();
    acf_in = make_snap(16'h0030); tick();
    update_in = 1'b0;
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("[TB] FAIL drop_count: got %h expected 0001", drop_cnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL drop_busy: got %b expected 1", busy); end
    tready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      base = (k < 9) ? 16'h0010 : 16'h0020;
      if ((k % 9) == 0) exp = {16'hAC0F, 16'(k / 9)};
      else exp = {16'h0, base + 16'((k % 9) - 1)};
      checks++; if (tvalid !== 1'b1 || tdata !== exp || tlast !== ((k % 9) == 8)) begin
        errors++; $display("[TB] FAIL drop_beat%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b", k, tvalid, tdata, tlast, exp, ((k % 9) == 8));
      end
      tick();
    end
    checks++; if (tvalid !== 1'b0) begin errors++; $display("[TB] FAIL drop_end_tvalid: got %b expected 0", tvalid); end
    checks++; if (seq !== 16'd2) begin errors++; $display("[TB] FAIL drop_seq: got %h expected 0002", seq); end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("[TB] FAIL drop_final: got %h expected 0001", drop_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    logic [15:0] base;
    do_reset();
    tready = 1'b1;
    acf_in = make_snap(16'h0040); update_in = 1'b1;
    tick();
    update_in = 1'b0;
    tick();
    for (int k = 0; k < 27; k++) begin
      base = (k < 9) ? 16'h0040 : ((k < 18) ? 16'h0050 : 16'h0060);
      if ((k % 9) == 0) exp = {16'hAC0F, 16'(k / 9)};
      else exp = {16'h0, base + 16'((k % 9) - 1)};
      checks++; if (tvalid !== 1'b1 || tdata !== exp || tlast !== ((k % 9) == 8)) begin
        errors++; $display("[TB] FAIL b2b_beat%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b", k, tvalid, tdata, tlast, exp, ((k % 9) == 8));
      end
      update_in = (k == 0) || (k == 8);
      acf_in = (k == 0) ? make_snap(16'h0050) : make_snap(16'h0060);
      tick();
    end
    update_in = 1'b0;
    checks++; if (tvalid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end_tvalid: got %b expected 0", tvalid); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("[TB] FAIL b2b_drop: got %h expected 0000", drop_cnt); end
    checks++; if (seq !== 16'd3) begin errors++; $display("[TB] FAIL b2b_seq: got %h expected 0003", seq); end
  endtask

  task automatic test_enable_reset();
    do_reset();
    tready = 1'b1; en = 1'b0;
    acf_in = make_snap(16'h0070); update_in = 1'b1;
    tick();
    update_in = 1'b0;
    tick(); tick();
    checks++; if (tvalid !== 1'b0 || busy !== 1'b0 || drop_cnt !== 16'd0) begin
      errors++; $display("[TB] FAIL en_low: got v=%b busy=%b drop=%h expected v=0 busy=0 drop=0000", tvalid, busy, drop_cnt);
    end
    en = 1'b1; update_in = 1'b1;
    tick();
    update_in = 1'b0;
    tick(); tick(); tick(); tick(); tick(); tick();
    checks++; if (tvalid !== 1'b1 || tdata !== 32'h00000074 || seq !== 16'd1) begin
      errors++; $display("[TB] FAIL rst_pre_bin4: got v=%b d=%h seq=%h expected v=1 d=00000074 seq=0001", tvalid, tdata, seq);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++; if (tvalid !== 1'b0 || tlast !== 1'b0 || seq !== 16'd0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_mid_frame: got v=%b l=%b seq=%h busy=%b expected v=0 l=0 seq=0000 busy=0", tvalid, tlast, seq, busy);
    end
    update_in = 1'b1;
    tick();
    update_in = 1'b0; en = 1'b0;
    tick();
    checks++; if (tvalid !== 1'b1 || tdata !== 32'hAC0F0000) begin
      errors++; $display("[TB] FAIL rst_next_header: got v=%b d=%h expected v=1 d=ac0f0000", tvalid, tdata);
    end
    for (int i = 0; i < 9; i++) tick();
    en = 1'b1;
    checks++; if (tvalid !== 1'b0 || seq !== 16'd1) begin
      errors++; $display("[TB] FAIL en_low_drain: got v=%b seq=%h expected v=0 seq=0001", tvalid, seq);
    end
  endtask

  task automatic test_seq_wrap();
    do_reset();
    force dut.seq_q = 16'hFFFF;
    tick();
    release dut.seq_q;
    #1;
    checks++; if (seq !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_preload: got %h expected ffff", seq); end
    tready = 1'b1;
    acf_in = make_snap(16'h0080); update_in = 1'b1;
    tick();
    update_in = 1'b0;
    tick();
    checks++; if (tvalid !== 1'b1 || tdata !== 32'hAC0FFFFF) begin
      errors++; $display("[TB] FAIL wrap_header_ffff: got v=%b d=%h expected v=1 d=ac0fffff", tvalid, tdata);
    end
    for (int i = 0; i < 9; i++) tick();
    checks++; if (tvalid !== 1'b0 || seq !== 16'h0000) begin
      errors++; $display("[TB] FAIL wrap_seq: got v=%b seq=%h expected v=0 seq=0000", tvalid, seq);
    end
    update_in = 1'b1;
    tick();
    update_in = 1'b0;
    tick();
    checks++; if (tvalid !== 1'b1 || tdata !== 32'hAC0F0000) begin
      errors++; $display("[TB] FAIL wrap_header_0000: got v=%b d=%h expected v=1 d=ac0f0000", tvalid, tdata);
    end
    for (int i = 0; i < 9; i++) tick();
  endtask

  task automatic test_drop_saturate();
    do_reset();
    tready = 1'b0;
    acf_in = make_snap(16'h0090); update_in = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    checks++; if (drop_cnt !== 16'd10) begin errors++; $display("[TB] FAIL sat_partial: got %h expected 000a", drop_cnt); end
    for (int i = 12; i < 65537; i++) tick();
    checks++; if (drop_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_reach: got %h expected ffff", drop_cnt); end
    for (int i = 0; i < 3; i++) tick();
    update_in = 1'b0;
    checks++; if (drop_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_hold: got %h expected ffff", drop_cnt); end
    checks++; if (tvalid !== 1'b1 || tdata !== 32'hAC0F0000) begin
      errors++; $display("[TB] FAIL sat_stalled_header: got v=%b d=%h expected v=1 d=ac0f0000", tvalid, tdata);
    end
  endtask

  initial begin
    RST = 1'b1; en = 1'b0; update_in = 1'b0; tready = 1'b0; acf_in = '0;
    $display("[TB] starting acf_axis_reader bench");
    test_reset();
    test_single();
    test_stall();
    test_drop();
    test_back_to_back();
    test_enable_reset();
    test_seq_wrap();
    test_drop_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
